// File: rtl/sniffer_pkg.sv
// sniffer_pkg: shared writer states, slot geometry and slot base helper for the result path.
package sniffer_pkg;
  typedef enum logic [2:0] {IDLE, PAYLOAD, HDR_HI, HDR_LO, ROTATE, SETTLE} wr_state_t;
  localparam int SLOT_BYTES = 1550;
  localparam int HDR_BYTES  = 2;
  localparam int PMAX       = SLOT_BYTES - HDR_BYTES;
  localparam int NUM_SLOTS  = 4;
  localparam logic [31:0] SLOT_BASE0 = 32'd0;
  function automatic logic [31:0] slot_base(input int unsigned i);
    return SLOT_BASE0 + 32'(i * SLOT_BYTES);
  endfunction
endpackage

// File: rtl/result_packet_writer.sv
// result_packet_writer: writes packet payload into the current slot, then a length/status header,
// and rotates the slot only for matched packets.
module result_packet_writer #(
  parameter int SLOT_BYTES = sniffer_pkg::SLOT_BYTES,
  parameter int HDR_BYTES  = sniffer_pkg::HDR_BYTES,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_match,
  output logic              in_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              inc_addr,
  output logic [15:0]       pkt_count,
  output logic [15:0]       drop_count
);
  import sniffer_pkg::*;
  localparam logic [LEN_W-1:0]  LIMIT = LEN_W'(SLOT_BYTES - HDR_BYTES);
  localparam logic [ADDR_W-1:0] HOFS  = ADDR_W'(HDR_BYTES);
  wr_state_t state, state_n;
  logic [ADDR_W-1:0] base_q, base_n, addr_n;
  logic [LEN_W-1:0] len, len_n;
  logic trunc, trunc_n, wen_n, inc_n, accept, in_pkt;
  logic [7:0] data_n;
  logic [15:0] pkt_n, drop_n;
  assign in_ready = (state == IDLE) || (state == PAYLOAD);
  assign accept   = in_valid && in_ready;
  // A byte belongs to a packet if it opens one or continues the open one.
  assign in_pkt   = in_sop || (state == PAYLOAD);
  always_comb begin
    state_n = state;
    base_n  = base_q;
    len_n   = len;
    trunc_n = trunc;
    wen_n   = 1'b0;
    addr_n  = mem_addr;
    data_n  = mem_wdata;
    inc_n   = 1'b0;
    pkt_n   = pkt_count;
    drop_n  = drop_count;
    case (state)
      IDLE, PAYLOAD: if (accept) begin
        if (in_sop) begin
          // Restart inside PAYLOAD keeps base_q: the slot has not rotated.
          base_n  = (state == IDLE) ? base_addr : base_q;
          wen_n   = 1'b1;
          addr_n  = base_n + HOFS;
          data_n  = in_data;
          len_n   = LEN_W'(1);
          trunc_n = 1'b0;
        end else if (state == PAYLOAD) begin
          wen_n   = len < LIMIT;
          addr_n  = (len < LIMIT) ? base_q + HOFS + ADDR_W'(len) : mem_addr;
          data_n  = (len < LIMIT) ? in_data : mem_wdata;
          len_n   = (len < LIMIT) ? len + LEN_W'(1) : len;
          trunc_n = trunc || !(len < LIMIT);
        end
        if (in_pkt) state_n = !in_eop ? PAYLOAD : in_match ? HDR_HI : IDLE;
        if (in_pkt && in_eop && !in_match) drop_n = drop_count + 16'd1;
      end
      HDR_HI: begin
        wen_n   = 1'b1;
        addr_n  = base_q;
        data_n  = {trunc, len[14:8]};
        state_n = HDR_LO;
      end
      HDR_LO: begin
        wen_n   = 1'b1;
        addr_n  = base_q + ADDR_W'(1);
        data_n  = len[7:0];
        state_n = ROTATE;
      end
      ROTATE: begin
        inc_n   = 1'b1;
        pkt_n   = pkt_count + 16'd1;
        state_n = SETTLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      len        <= '0;
      trunc      <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inc_addr   <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state      <= state_n;
      base_q     <= base_n;
      len        <= len_n;
      trunc      <= trunc_n;
      mem_wen    <= wen_n;
      mem_addr   <= addr_n;
      mem_wdata  <= data_n;
      inc_addr   <= inc_n;
      pkt_count  <= pkt_n;
      drop_count <= drop_n;
    end
  end
endmodule

// File: tb/tb_result_packet_writer.sv
// tb_result_packet_writer: directed packets with a write scoreboard for result_packet_writer.
module tb_result_packet_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] base_addr = '0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_match = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, mem_wen, inc_addr;
  logic [31:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [15:0] pkt_count, drop_count;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int compared = 0, mismatched = 0, busy = 0, incs = 0;

  result_packet_writer dut (
    .clk(clk), .rst(rst), .base_addr(base_addr), .in_valid(in_valid), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_match(in_match), .in_ready(in_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .inc_addr(inc_addr),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic cyc();
    wr_t e;
    @(posedge clk);
    #1;
    if (mem_wen) begin
      if (exp_q.size() == 0) chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
      end
    end
    if (inc_addr) incs++;
    if (!in_ready) busy++;
  endtask

  task automatic send(input logic [7:0] d, input logic s, input logic e, input logic m);
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_match = m;
    cyc();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_match = 1'b0;
  endtask

  task automatic start();
    busy = 0;
    incs = 0;
  endtask

  task automatic drain(input string tag, input int exp_busy, input int exp_inc);
    for (int i = 0; i < 20 && !in_ready; i++) cyc();
    repeat (3) cyc();
    chk({tag, "_busy"}, busy, exp_busy);
    chk({tag, "_inc"}, incs, exp_inc);
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 1);
    chk("rst_wen", {31'd0, mem_wen}, 0);
    chk("rst_inc", {31'd0, inc_addr}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pkt", {16'd0, pkt_count}, 0);
    chk("rst_drop", {16'd0, drop_count}, 0);
    rst = 1'b0;

    // 1: matched 4-byte packet at slot 0
    start();
    base_addr = 32'h0000;
    push(32'h2, 8'hAA); push(32'h3, 8'hBB); push(32'h4, 8'hCC); push(32'h5, 8'hDD);
    push(32'h0, 8'h00); push(32'h1, 8'h04);
    send(8'hAA, 1, 0, 0); send(8'hBB, 0, 0, 0); send(8'hCC, 0, 0, 0); send(8'hDD, 0, 1, 1);
    drain("t1", 4, 1);
    chk("t1_pkt", {16'd0, pkt_count}, 1);

    // 2: unmatched packet then matched packet reusing the slot
    start();
    base_addr = 32'h060E;
    push(32'h0610, 8'h01); push(32'h0611, 8'h02); push(32'h0612, 8'h03);
    send(8'h01, 1, 0, 0); send(8'h02, 0, 0, 1); send(8'h03, 0, 1, 0);
    drain("t2a", 0, 0);
    chk("t2_drop", {16'd0, drop_count}, 1);
    start();
    push(32'h0610, 8'h11); push(32'h0611, 8'h22); push(32'h060E, 8'h00); push(32'h060F, 8'h02);
    send(8'h11, 1, 0, 0); send(8'h22, 0, 1, 1);
    drain("t2b", 4, 1);
    chk("t2_pkt", {16'd0, pkt_count}, 2);

    // 3: oversize packet truncates at 1548 bytes
    start();
    base_addr = 32'h0C1C;
    for (int i = 0; i < 1548; i++) push(32'h0C1E + 32'(i), 8'(i * 7));
    push(32'h0C1C, 8'h86); push(32'h0C1D, 8'h0C);
    for (int i = 0; i < 1600; i++) send(8'(i * 7), i == 0, i == 1599, i == 1599);
    drain("t3", 4, 1);
    chk("t3_pkt", {16'd0, pkt_count}, 3);

    // 4: single-byte packet
    start();
    base_addr = 32'h1838;
    push(32'h183A, 8'h5A); push(32'h1838, 8'h00); push(32'h1839, 8'h01);
    send(8'h5A, 1, 1, 1);
    drain("t4", 4, 1);
    chk("t4_pkt", {16'd0, pkt_count}, 4);

    // 5: SOP mid-packet restarts at the latched base; base_addr changes are ignored
    start();
    base_addr = 32'h0000;
    push(32'h2, 8'h31); push(32'h3, 8'h32); push(32'h4, 8'h33);
    push(32'h2, 8'h41); push(32'h3, 8'h42); push(32'h0, 8'h00); push(32'h1, 8'h02);
    send(8'h31, 1, 0, 0);
    base_addr = 32'h9999;
    send(8'h32, 0, 0, 0); send(8'h33, 0, 0, 0);
    send(8'h41, 1, 0, 0); send(8'h42, 0, 1, 1);
    drain("t5", 4, 1);
    chk("t5_pkt", {16'd0, pkt_count}, 5);
    chk("t5_drop", {16'd0, drop_count}, 1);

    // 6: asynchronous reset mid-packet, then a normal packet
    start();
    base_addr = 32'h060E;
    for (int i = 0; i < 10; i++) push(32'h0610 + 32'(i), 8'(8'hE0 + i));
    for (int i = 0; i < 10; i++) send(8'(8'hE0 + i), i == 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ready", {31'd0, in_ready}, 1);
    chk("t6_rst_wen", {31'd0, mem_wen}, 0);
    chk("t6_rst_pkt", {16'd0, pkt_count}, 0);
    chk("t6_rst_drop", {16'd0, drop_count}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    push(32'h0610, 8'h77); push(32'h0611, 8'h88); push(32'h060E, 8'h00); push(32'h060F, 8'h02);
    send(8'h77, 1, 0, 0); send(8'h88, 0, 1, 1);
    drain("t6", 4, 1);
    chk("t6_pkt", {16'd0, pkt_count}, 1);
    chk("t6_drop", {16'd0, drop_count}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/result_packet_writer.md
Name: result_packet_writer

Overview:
- Downstream consumer of the match pipeline's byte stream; sits in front of `result_address_fsm`.
- Writes each packet into the current output slot at a 2-byte header offset, then writes a length/status header at the slot base.
- Matched packets: pulses `inc_addr` so `result_address_fsm` rotates to the next slot.
- Unmatched packets: discarded; the slot is reused for the next packet.

Parameters:
- SLOT_BYTES, 1550: bytes per output slot, header included.
- HDR_BYTES, 2: header bytes at the slot base.
- ADDR_W, 32: memory address width.
- LEN_W, 16: width of the length counter and header field.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- base_addr  in  ADDR_W  current slot base from `result_address_fsm`
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_sop  in  1  first byte of packet
- in_eop  in  1  last byte of packet
- in_match  in  1  packet matched a filter; sampled only with in_eop
- in_ready  out  1  block accepts a byte this cycle
- mem_wen  out  1  output memory byte write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  write data
- inc_addr  out  1  one-cycle pulse that rotates the slot
- pkt_count  out  16  matched packets committed, wraps
- drop_count  out  16  unmatched packets discarded, wraps

Behaviour:
- Reset is asynchronous, active-high, and may occur mid-packet.
  - state=IDLE
  - all outputs 0
  - except in_ready, which is 1 (combinational from state)
  - the partial slot is abandoned and the header is not written
- A byte is accepted when in_valid & in_ready.
- Outputs mem_* and inc_addr are registered: an accepted byte appears on mem_* the next cycle, one write per accepted byte.
- Internal registers:
  - base_q: base_addr latched on SOP
  - len: LEN_W bits, payload bytes accepted
  - trunc: set once the payload limit is exceeded
- Payload limit PMAX = SLOT_BYTES - HDR_BYTES = 1548.
- IDLE (in_ready=1):
  - Accepted byte with in_sop: latch base_q, write at base_addr+2, len=1, trunc=0.
    - With in_eop on the same byte: go to HDR_HI if in_match, else count a drop and stay in IDLE.
    - Otherwise go to PAYLOAD.
  - Accepted byte without in_sop: dropped silently, no write.
- PAYLOAD (in_ready=1):
  - Each accepted byte: if len < PMAX, write at base_q+2+len and increment len; else no write, trunc=1, len holds.
  - in_eop byte follows the same rule, then: in_match goes to HDR_HI; otherwise drop_count++ and go to IDLE (slot reused, no header, no inc_addr).
  - in_sop in PAYLOAD aborts the current packet (no header, no counts) and restarts it as a new SOP at base_q. base_addr is not re-sampled because the slot has not rotated.
- HDR_HI (in_ready=0): write {trunc, len[14:8]} at base_q.
- HDR_LO (in_ready=0): write len[7:0] at base_q+1.
- ROTATE (in_ready=0): inc_addr=1 for exactly one cycle; pkt_count++.
- SETTLE (in_ready=0): one cycle so `result_address_fsm` updates its registered base_addr; then IDLE.
- Commit timing: from the eop acceptance edge, there are 4 cycles until in_ready returns to 1.
- Header length field is payload bytes written, at most 1548, so it fits 15 bits.
- Counters wrap at 2^16.
- Address arithmetic is modulo 2^ADDR_W.
- base_addr changes outside IDLE are ignored.

Decomposition:
- Package `sniffer_pkg`:
  - wr_state_t enum {IDLE, PAYLOAD, HDR_HI, HDR_LO, ROTATE, SETTLE}
  - SLOT_BYTES, HDR_BYTES, PMAX constants
  - slot base address constants shared with `result_address_fsm`
- Single module; no sub-module needed.
- Optional top-level harness `result_path` instantiates this block with `result_address_fsm` for integration tests.

Test Plan:
1. Reset, then matched 4-byte packet AA BB CC DD at base 0x0000 → writes:
   - 0x0002=AA, 0x0003=BB, 0x0004=CC, 0x0005=DD
   - then 0x0000=00, 0x0001=04
   - inc_addr pulses once, pkt_count=1, in_ready low for exactly 4 cycles.
2. Unmatched 3-byte packet at base 0x060E, then matched 2-byte packet 11 22 → second packet lands at 0x0610/0x0611, header 00 02 at 0x060E; drop_count=1; no inc_addr after the first packet.
3. Matched 1600-byte packet at base 0x0C1C → exactly 1548 payload writes; header bytes 0x86, 0x0C (trunc=1, len=1548); inc_addr pulses once.
4. Single-byte packet with sop=eop=1, match=1, data 5A at base 0x1838 → write 0x183A=5A; header 00 01; inc_addr pulses.
5. SOP arrives mid-packet after 3 bytes → new packet restarts at base_q+2; final header reflects only the new packet's length; pkt_count increments once.
6. rst asserted during PAYLOAD after 10 bytes, then a matched 2-byte packet → no header for the aborted packet; counts are 0 before the new packet; new packet is written from base_addr+2 normally.
